// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// Loader FSM states and byte-lane geometry of a packed instruction word.
package imem_loader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DONE  = 2'd2,
    ERROR = 2'd3
  } state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam logic [7:0] PAD_BYTE = 8'h00;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Little-endian byte-to-word assembler. word_valid_o is a combinational pulse on the
// handshake that completes a word; word_o is the completed word, zero-padded on a short last word.
module imem_loader_byte_packer
  import imem_loader_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clear_i,
  input  logic        push_i,
  input  logic [7:0]  data_i,
  input  logic        last_i,
  output logic        word_valid_o,
  output logic [31:0] word_o
);

  logic [1:0]  idx_reg;
  logic [31:0] pack_reg;

  assign word_valid_o = push_i & (last_i | (idx_reg == 2'(BYTES_PER_WORD - 1)));

  // Lanes below the index come from the accumulator, the current lane from the
  // incoming byte, and anything above it is padding.
  generate
    for (genvar gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_lane
      assign word_o[8*gi +: 8] = (2'(gi) < idx_reg)  ? pack_reg[8*gi +: 8] :
                                 (2'(gi) == idx_reg) ? data_i : PAD_BYTE;
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      idx_reg  <= 2'd0;
      pack_reg <= 32'd0;
    end else if (clear_i || word_valid_o) begin
      idx_reg  <= 2'd0;
      pack_reg <= 32'd0;
    end else if (push_i) begin
      pack_reg[8*idx_reg +: 8] <= data_i;
      idx_reg                  <= idx_reg + 2'd1;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Streams program bytes into instruction memory one 32-bit word at a time and
// releases the CPU (cpu_start_o) only after the full image has been written.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int CNT_W       = $clog2(DEPTH_WORDS) + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_req_i,
  input  logic             byte_valid_i,
  input  logic [7:0]       byte_data_i,
  input  logic             byte_last_i,
  output logic             byte_ready_o,
  output logic             mem_we_o,
  output logic [31:0]      mem_addr_o,
  output logic [31:0]      mem_data_o,
  output logic             cpu_start_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] words_o,
  output logic             overflow_err_o
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  state_t           state_reg, state_next;
  state_t           drain_to_reg, drain_to_next;
  logic             drain_reg, drain_next;
  logic             start;
  logic             handshake;
  logic             word_done;
  logic [31:0]      word;
  logic [CNT_W-1:0] word_cnt_reg;
  logic             we_reg;
  logic [31:0]      addr_reg;
  logic [31:0]      data_reg;

  // While draining the final (or overflowing) word, the loader stays in LOAD
  // but refuses bytes until the write has gone out.
  assign byte_ready_o   = (state_reg == LOAD) && !drain_reg;
  assign handshake      = byte_valid_i & byte_ready_o;
  assign busy_o         = (state_reg == LOAD);
  assign cpu_start_o    = (state_reg == DONE);
  assign overflow_err_o = (state_reg == ERROR);
  assign words_o        = word_cnt_reg;
  assign mem_we_o       = we_reg;
  assign mem_addr_o     = addr_reg;
  assign mem_data_o     = data_reg;

  imem_loader_byte_packer u_packer (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .clear_i      (start),
    .push_i       (handshake),
    .data_i       (byte_data_i),
    .last_i       (byte_last_i),
    .word_valid_o (word_done),
    .word_o       (word)
  );

  always_comb begin
    state_next    = state_reg;
    drain_next    = drain_reg;
    drain_to_next = drain_to_reg;
    start         = 1'b0;
    case (state_reg)
      IDLE, DONE, ERROR: begin
        if (load_req_i) begin
          state_next = LOAD;
          start      = 1'b1;
        end
      end
      LOAD: begin
        if (drain_reg) begin
          state_next = drain_to_reg;
          drain_next = 1'b0;
        end else if (word_done) begin
          if (byte_last_i) begin
            drain_next    = 1'b1;
            drain_to_next = DONE;
          end else if (word_cnt_reg == CNT_W'(DEPTH_WORDS - 1)) begin
            drain_next    = 1'b1;
            drain_to_next = ERROR;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_reg    <= IDLE;
      drain_reg    <= 1'b0;
      drain_to_reg <= IDLE;
      word_cnt_reg <= '0;
      we_reg       <= 1'b0;
      addr_reg     <= 32'd0;
      data_reg     <= 32'd0;
    end else begin
      state_reg    <= state_next;
      drain_reg    <= drain_next;
      drain_to_reg <= drain_to_next;
      we_reg       <= word_done;
      if (start) begin
        word_cnt_reg <= '0;
      end else if (word_done) begin
        word_cnt_reg <= word_cnt_reg + CNT_W'(1);
      end
      if (word_done) begin
        addr_reg <= {{(32 - IDX_W - 2){1'b0}}, word_cnt_reg[IDX_W-1:0], 2'b00};
        data_reg <= word;
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed and randomized byte images checked
// against a word-level model of the expected memory writes.
module tb_imem_loader;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          load_req_i;
  logic          byte_valid_i;
  logic [7:0]    byte_data_i;
  logic          byte_last_i;
  logic          byte_ready_o;
  logic          mem_we_o;
  logic [31:0]   mem_addr_o;
  logic [31:0]   mem_data_o;
  logic          cpu_start_o;
  logic          busy_o;
  logic [CW-1:0] words_o;
  logic          overflow_err_o;

  imem_loader #(.DEPTH_WORDS(DEPTH), .CNT_W(CW)) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .load_req_i     (load_req_i),
    .byte_valid_i   (byte_valid_i),
    .byte_data_i    (byte_data_i),
    .byte_last_i    (byte_last_i),
    .byte_ready_o   (byte_ready_o),
    .mem_we_o       (mem_we_o),
    .mem_addr_o     (mem_addr_o),
    .mem_data_o     (mem_data_o),
    .cpu_start_o    (cpu_start_o),
    .busy_o         (busy_o),
    .words_o        (words_o),
    .overflow_err_o (overflow_err_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          checks   = 0;
  int          failures = 0;
  int          wr_cyc_q[$];
  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  int          hs_cyc_q[$];
  logic [7:0]  img_q[$];

  always @(negedge clk) begin
    if (mem_we_o === 1'b1) begin
      wr_cyc_q.push_back(cyc);
      wr_addr_q.push_back(mem_addr_o);
      wr_data_q.push_back(mem_data_o);
    end
  end

  task automatic clear_logs();
    wr_cyc_q.delete();
    wr_addr_q.delete();
    wr_data_q.delete();
    hs_cyc_q.delete();
  endtask

  task automatic pulse_load();
    @(negedge clk);
    load_req_i = 1'b1;
    @(negedge clk);
    load_req_i = 1'b0;
  endtask

  task automatic push_byte(input logic [7:0] d, input logic l, input int gap);
    int n;
    repeat (gap) begin
      @(negedge clk);
      byte_valid_i = 1'b0;
    end
    @(negedge clk);
    byte_valid_i = 1'b1;
    byte_data_i  = d;
    byte_last_i  = l;
    n = 0;
    while (byte_ready_o !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++; failures++;
      $display("FAIL handshake_timeout byte=%h ready=%b required=1", d, byte_ready_o);
    end else begin
      @(posedge clk);
      #1;
      hs_cyc_q.push_back(cyc);
    end
  endtask

  task automatic end_stream();
    @(negedge clk);
    byte_valid_i = 1'b0;
    byte_last_i  = 1'b0;
  endtask

  task automatic wait_settle();
    int n = 0;
    while (cpu_start_o !== 1'b1 && overflow_err_o !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 20) begin
      failures++;
      $display("FAIL settle_timeout cpu_start=%b overflow=%b required=one_high", cpu_start_o, overflow_err_o);
    end
  endtask

  // Loads img_q as one image (last on the final byte) and compares the resulting
  // memory writes with words built directly from the byte list.
  task automatic load_and_check(input string name, input int gmin, input int gmax,
                                input bit inject_req);
    logic [31:0] exp_w[$];
    int nw, sz, hi;
    sz = img_q.size();
    nw = (sz + 3) / 4;
    clear_logs();
    pulse_load();
    for (int i = 0; i < sz; i++) begin
      if (inject_req && i == 1) load_req_i = 1'b1;
      push_byte(img_q[i], (i == sz - 1), int'($urandom_range(gmax, gmin)));
      load_req_i = 1'b0;
    end
    end_stream();
    wait_settle();
    for (int w = 0; w < nw; w++) exp_w.push_back(32'h0);
    for (int i = 0; i < sz; i++) exp_w[i/4] = exp_w[i/4] | (32'(img_q[i]) << (8 * (i % 4)));
    checks++;
    if (wr_addr_q.size() != nw) begin
      failures++;
      $display("FAIL %s write_count got=%0d exp=%0d", name, wr_addr_q.size(), nw);
    end else begin
      for (int w = 0; w < nw; w++) begin
        hi = (4 * w + 3 < sz - 1) ? 4 * w + 3 : sz - 1;
        checks++;
        if (wr_addr_q[w] !== 32'(4 * w) || wr_data_q[w] !== exp_w[w]) begin
          failures++;
          $display("FAIL %s write%0d got=@%h:%h exp=@%h:%h", name, w, wr_addr_q[w],
                   wr_data_q[w], 32'(4 * w), exp_w[w]);
        end
        checks++;
        if (wr_cyc_q[w] != hs_cyc_q[hi]) begin
          failures++;
          $display("FAIL %s write%0d_timing got_cycle=%0d exp_cycle=%0d", name, w,
                   wr_cyc_q[w], hs_cyc_q[hi]);
        end
      end
    end
    checks++;
    if (words_o !== CW'(nw) || cpu_start_o !== 1'b1 || busy_o !== 1'b0 ||
        byte_ready_o !== 1'b0 || overflow_err_o !== 1'b0) begin
      failures++;
      $display("FAIL %s done_status got=words%0d/start%b/busy%b/rdy%b/ovf%b exp=words%0d/1/0/0/0",
               name, words_o, cpu_start_o, busy_o, byte_ready_o, overflow_err_o, nw);
    end
    checks++;
    if (mem_addr_o !== 32'(4 * (nw - 1)) || mem_data_o !== exp_w[nw-1] || mem_we_o !== 1'b0) begin
      failures++;
      $display("FAIL %s hold got=we%b@%h:%h exp=we0@%h:%h", name, mem_we_o, mem_addr_o,
               mem_data_o, 32'(4 * (nw - 1)), exp_w[nw-1]);
    end
    $display("%s: %0d bytes, %0d words", name, sz, nw);
  endtask

  task automatic check_all_zero(input string name);
    checks++;
    if (byte_ready_o !== 1'b0 || mem_we_o !== 1'b0 || mem_addr_o !== 32'd0 ||
        mem_data_o !== 32'd0 || cpu_start_o !== 1'b0 || busy_o !== 1'b0 ||
        words_o !== '0 || overflow_err_o !== 1'b0) begin
      failures++;
      $display("FAIL %s outputs got=rdy%b we%b a%h d%h st%b bsy%b w%0d ovf%b exp=all_zero",
               name, byte_ready_o, mem_we_o, mem_addr_o, mem_data_o, cpu_start_o, busy_o,
               words_o, overflow_err_o);
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b0; load_req_i = 1'b1; byte_valid_i = 1'b0; byte_data_i = 8'h00; byte_last_i = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset_with_load_req");
    rst_i = 1'b1; load_req_i = 1'b0;
    @(negedge clk);
    check_all_zero("idle_after_reset");
    $display("test_reset done");
  endtask

  task automatic test_program8();
    img_q = '{8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'h50, 8'h00};
    load_and_check("program8", 0, 0, 1'b0);
    checks++;
    if (wr_data_q.size() != 2 || wr_data_q[0] !== 32'h00A00513 || wr_data_q[1] !== 32'h00500593) begin
      failures++;
      $display("FAIL program8_literal got_n=%0d exp=00a00513,00500593", wr_data_q.size());
    end
  endtask

  task automatic test_partial6();
    img_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    load_and_check("partial6", 0, 0, 1'b0);
    checks++;
    if (wr_data_q.size() != 2 || wr_data_q[1] !== 32'h00006655) begin
      failures++;
      $display("FAIL partial6_pad got_n=%0d exp=00006655", wr_data_q.size());
    end
  endtask

  task automatic test_valid_toggle();
    img_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    load_and_check("valid_toggle", 1, 1, 1'b0);
    checks++;
    if (wr_data_q.size() != 1 || wr_data_q[0] !== 32'hDDCCBBAA) begin
      failures++;
      $display("FAIL valid_toggle_word got_n=%0d exp=ddccbbaa", wr_data_q.size());
    end
  endtask

  task automatic test_reload_from_done();
    clear_logs();
    @(negedge clk);
    load_req_i = 1'b1;
    @(negedge clk);
    load_req_i = 1'b0;
    checks++;
    if (cpu_start_o !== 1'b0 || words_o !== '0 || busy_o !== 1'b1 || byte_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL reload_entry got=st%b w%0d bsy%b rdy%b exp=st0 w0 bsy1 rdy1",
               cpu_start_o, words_o, busy_o, byte_ready_o);
    end
    push_byte(8'h5A, 1'b1, 0);
    end_stream();
    wait_settle();
    checks++;
    if (wr_addr_q.size() != 1 || wr_addr_q[0] !== 32'd0 || wr_data_q[0] !== 32'h0000005A) begin
      failures++;
      $display("FAIL reload_write got_n=%0d exp=@0:0000005a", wr_addr_q.size());
    end
    $display("test_reload_from_done done");
  endtask

  task automatic test_random();
    int sz;
    for (int it = 0; it < 15; it++) begin
      sz = int'($urandom_range(16, 1));
      img_q.delete();
      for (int i = 0; i < sz; i++) img_q.push_back(8'($urandom));
      load_and_check($sformatf("random%0d", it), 0, 2, 1'($urandom_range(1, 0)));
    end
  endtask

  task automatic test_overflow();
    bit accepted = 1'b0;
    clear_logs();
    pulse_load();
    for (int i = 0; i < 16; i++) push_byte(8'(i + 1), 1'b0, 0);
    @(negedge clk);
    byte_valid_i = 1'b1; byte_data_i = 8'h77; byte_last_i = 1'b0;
    checks++;
    if (mem_we_o !== 1'b1 || byte_ready_o !== 1'b0) begin
      failures++;
      $display("FAIL overflow_final_write got=we%b rdy%b exp=we1 rdy0", mem_we_o, byte_ready_o);
    end
    repeat (5) begin
      @(negedge clk);
      if (byte_ready_o !== 1'b0) accepted = 1'b1;
    end
    end_stream();
    checks++;
    if (accepted) begin
      failures++;
      $display("FAIL overflow_17th got=ready_seen exp=never_ready");
    end
    checks++;
    if (wr_addr_q.size() != 4) begin
      failures++;
      $display("FAIL overflow_write_count got=%0d exp=4", wr_addr_q.size());
    end else begin
      for (int w = 0; w < 4; w++) begin
        checks++;
        if (wr_addr_q[w] !== 32'(4 * w) ||
            wr_data_q[w] !== {8'(4*w+4), 8'(4*w+3), 8'(4*w+2), 8'(4*w+1)}) begin
          failures++;
          $display("FAIL overflow_write%0d got=@%h:%h exp=@%h:%h", w, wr_addr_q[w], wr_data_q[w],
                   32'(4 * w), {8'(4*w+4), 8'(4*w+3), 8'(4*w+2), 8'(4*w+1)});
        end
      end
    end
    checks++;
    if (overflow_err_o !== 1'b1 || cpu_start_o !== 1'b0 || busy_o !== 1'b0 ||
        byte_ready_o !== 1'b0 || words_o !== CW'(4)) begin
      failures++;
      $display("FAIL overflow_status got=ovf%b st%b bsy%b rdy%b w%0d exp=ovf1 st0 bsy0 rdy0 w4",
               overflow_err_o, cpu_start_o, busy_o, byte_ready_o, words_o);
    end
    $display("test_overflow done");
    img_q = '{8'hC1, 8'hC2, 8'hC3};
    load_and_check("recover_from_error", 0, 0, 1'b0);
  endtask

  task automatic test_reset_midload();
    clear_logs();
    pulse_load();
    for (int i = 0; i < 3; i++) push_byte(8'hE0 + 8'(i), 1'b0, 0);
    @(negedge clk);
    rst_i = 1'b0;
    byte_data_i = 8'hE3;
    @(negedge clk);
    check_all_zero("reset_midload");
    checks++;
    if (wr_addr_q.size() != 0) begin
      failures++;
      $display("FAIL reset_midload_writes got=%0d exp=0", wr_addr_q.size());
    end
    rst_i = 1'b1;
    byte_valid_i = 1'b0;
    @(negedge clk);
    img_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    load_and_check("after_reset", 0, 1, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=no_finish exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_program8();
    test_partial6();
    test_valid_toggle();
    test_reload_from_done();
    test_random();
    test_overflow();
    test_reset_midload();
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Writer side of the instruction-memory interface. It accepts a byte stream over a valid/ready handshake and packs it little-endian into 32-bit words. Each word is written sequentially into the instruction memory write port, starting at byte address 0. The block holds the CPU's start input low while loading and raises it once the program image is fully written.

Parameters:
DEPTH_WORDS, 256, instruction memory capacity in 32-bit words (power of 2, >=4)
CNT_W, $clog2(DEPTH_WORDS)+1, width of word counter/status

Ports:
clk_i  in  1  clock, all logic on rising edge
rst_i  in  1  reset, synchronous, active-low
load_req_i  in  1  single-cycle pulse: begin new image load
byte_valid_i  in  1  byte_data_i valid
byte_data_i  in  8  program byte
byte_last_i  in  1  qualifies final byte of image (sampled with valid)
byte_ready_o  out  1  loader can accept byte this cycle
mem_we_o  out  1  instruction memory write strobe, one cycle per word
mem_addr_o  out  32  byte address of word being written (word-aligned)
mem_data_o  out  32  word being written
cpu_start_o  out  1  drives CPU start_i; high only when image complete
busy_o  out  1  high in LOAD
words_o  out  CNT_W  number of words written in last/current load
overflow_err_o  out  1  image exceeded DEPTH_WORDS

Behaviour:
- Reset (rst_i==0 at clk edge): state IDLE. All outputs 0, word counter 0, byte index 0, pack register 0. Reset mid-load aborts immediately. Memory contents already written are not restored.
- States: IDLE, LOAD, DONE, ERROR.
- IDLE: byte_ready_o=0. load_req_i=1 -> LOAD; clear word counter, byte index, pack register, overflow_err_o.
- LOAD: byte_ready_o=1, busy_o=1. Handshake = byte_valid_i & byte_ready_o. Bytes arriving while ready=0 are ignored by the loader; the source must hold them.
- Packing: byte index k (0..3) lands in bits [8k+7:8k]. Byte index increments on each handshake and wraps 3->0.
- Word complete when a handshake occurs at k==3, or on a handshake with byte_last_i=1 at any k.
- Partial words on last: unfilled upper bytes are 0x00.
- Write timing: registered. mem_we_o=1 for exactly one cycle, in the cycle after the completing handshake.
  - mem_addr_o = 4*word_index and mem_data_o = packed word in that cycle.
  - Word counter increments in the same cycle.
  - mem_addr_o/mem_data_o hold their last values when mem_we_o=0.
- Back-to-back: ready stays 1 while a write is pending, so a new byte may be accepted in the write cycle. This gives full rate of one byte per cycle.
- Last byte: after its handshake, byte_ready_o drops next cycle. The final write occurs that cycle, then the state goes to DONE.
- Overflow: if a word completes at word_index==DEPTH_WORDS-1 without byte_last_i, that word is still written. Next state is ERROR.
- ERROR: overflow_err_o=1, byte_ready_o=0, cpu_start_o=0. Exit only via load_req_i (-> LOAD) or reset.
- DONE: cpu_start_o=1 held, busy_o=0, words_o = total words written. load_req_i -> LOAD; cpu_start_o=0 from the next cycle.
- load_req_i while in LOAD: ignored.
- Simultaneous load_req_i and reset: reset wins.
- words_o: live counter during LOAD, frozen in DONE/ERROR. Width CNT_W so DEPTH_WORDS is representable.
- mem_addr_o upper bits beyond $clog2(DEPTH_WORDS)+2 are always 0.

Decomposition:
- Package imem_loader_pkg: state enum {IDLE, LOAD, DONE, ERROR}, BYTES_PER_WORD=4, PAD_BYTE=8'h00.
- One sub-module: byte_packer. It holds the 4-byte little-endian assembler with byte index, pad-on-last, and a word_valid pulse. The top-level module holds the FSM, counter and write register.

Test Plan:
- Load 8 bytes 13 05 A0 00 | 93 05 50 00 (last on 8th), one per cycle -> two writes: addr 0 data 0x00A00513, addr 4 data 0x00500593; DONE, words_o=2, cpu_start_o=1.
- Load 6 bytes 11 22 33 44 55 66 (last on 6th) -> writes 0x44332211 @0, 0x00006655 @4; words_o=2.
- Valid toggling 1/0 every cycle, bytes AA BB CC DD last -> one write 0xDDCCBBAA @0, exactly one cycle after the 4th handshake; no write before it.
- DEPTH_WORDS=4, stream 17 bytes with no last -> 4 writes (addr 0..12), ERROR, overflow_err_o=1, byte_ready_o=0, cpu_start_o=0, 17th byte not accepted.
- Reset asserted after 3 bytes of a load -> next cycle all outputs 0, state IDLE, no write issued; a new load_req_i restarts at addr 0.
- In DONE pulse load_req_i -> cpu_start_o=0 next cycle, words_o restarts at 0, first new word written at addr 0.
